// File: rtl/pipelined_segment_adder_if.sv
// rtl/pipelined_segment_adder_if.sv - operand/result stream bundle for pipelined_segment_adder
// Purpose: groups the operand stream (in_*) and result stream (out_*) handshakes.
// Ports (signals):
//   in_valid/in_ready      operand beat handshake
//   in_a/in_b              operands, WIDTH bits
//   in_cin/in_sub          carry-in (add only), 1 = subtract
//   out_valid/out_ready    result beat handshake
//   out_sum/out_cout/out_ovf  result, carry-out, signed overflow
// Modports: master = producer/consumer side, slave = adder side.
interface pipelined_segment_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/pipelined_segment_adder.sv
// rtl/pipelined_segment_adder.sv - pipelined segmented add/subtract with valid/ready stream
// Purpose: WIDTH-bit A+B+cin or A-B split into STAGES = WIDTH/SEG segments,
//   one segment added per pipeline stage, carry registered between stages.
//   Globally stalled pipeline: every stage shifts when the output slot is
//   empty or being consumed, otherwise everything holds.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   ifc  pipelined_segment_adder_if.slave (operand and result streams)
// Optional feature: macro PIPE_ADDER_OVF_EN enables the signed overflow flag;
//   when undefined out_ovf is tied to 0.
module pipelined_segment_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input logic                      clk,
  input logic                      rst,
  pipelined_segment_adder_if.slave ifc
);
  localparam int STAGES = WIDTH / SEG;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Output slot empty or being drained: whole pipeline may move.
  assign adv          = !ifc.out_valid || ifc.out_ready;
  assign ifc.in_ready = adv;

  // Subtract as A + ~B + 1; the external carry-in only matters when adding.
  assign b_eff = ifc.in_sub ? ~ifc.in_b : ifc.in_b;
  assign c0    = ifc.in_sub | ifc.in_cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LOW = (k + 1) * SEG;

    logic [SEG-1:0] a_seg;
    logic [SEG-1:0] b_seg;
    logic           c_in;
    logic           vld_in;
    logic [SEG:0]   seg_sum;
    logic [LOW-1:0] sum_d;
    logic           vld_q;
    logic           c_q;
    logic [LOW-1:0] sum_q;

    if (k == 0) begin : g_head
      assign a_seg  = ifc.in_a[SEG-1:0];
      assign b_seg  = b_eff[SEG-1:0];
      assign c_in   = c0;
      assign vld_in = ifc.in_valid;
      assign sum_d  = seg_sum[SEG-1:0];
    end else begin : g_body
      assign a_seg  = g_stg[k-1].g_rem.a_rem_q[SEG-1:0];
      assign b_seg  = g_stg[k-1].g_rem.b_rem_q[SEG-1:0];
      assign c_in   = g_stg[k-1].c_q;
      assign vld_in = g_stg[k-1].vld_q;
      assign sum_d  = {seg_sum[SEG-1:0], g_stg[k-1].sum_q};
    end

    // Full SEG+1 bit add so the segment carry is extracted before truncation.
    assign seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, c_in};

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        vld_q <= vld_in;
        c_q   <= seg_sum[SEG];
        sum_q <= sum_d;
      end
    end

    // Unconsumed upper operand segments travel with the beat, shifted down
    // so the next stage always reads its segment from bit 0. The operand
    // sign bits ride along in the top segment.
    if (k < STAGES - 1) begin : g_rem
      localparam int REM = WIDTH - LOW;

      logic [REM-1:0] a_rem_d;
      logic [REM-1:0] b_rem_d;
      logic [REM-1:0] a_rem_q;
      logic [REM-1:0] b_rem_q;

      if (k == 0) begin : g_src
        assign a_rem_d = ifc.in_a[WIDTH-1:SEG];
        assign b_rem_d = b_eff[WIDTH-1:SEG];
      end else begin : g_src
        assign a_rem_d = g_stg[k-1].g_rem.a_rem_q[REM+SEG-1:SEG];
        assign b_rem_d = g_stg[k-1].g_rem.b_rem_q[REM+SEG-1:SEG];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else if (adv) begin
          a_rem_q <= a_rem_d;
          b_rem_q <= b_rem_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_tail
      assign ifc.out_valid = vld_q;
      assign ifc.out_sum   = sum_q;
      assign ifc.out_cout  = c_q;
`ifdef PIPE_ADDER_OVF_EN
      logic ovf_q;

      // Same-sign operands producing a result of the other sign.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= (a_seg[SEG-1] == b_seg[SEG-1]) && (seg_sum[SEG-1] != a_seg[SEG-1]);
        end
      end
      assign ifc.out_ovf = ovf_q;
`else
      assign ifc.out_ovf = 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_pipelined_segment_adder.sv
// tb/tb_pipelined_segment_adder.sv - self-checking bench for pipelined_segment_adder
module tb_pipelined_segment_adder;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
`ifdef PIPE_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic clk;
  logic rst;

  pipelined_segment_adder_if #(.WIDTH(WIDTH)) ifc ();
  pipelined_segment_adder_if #(.WIDTH(WIDTH)) ifc1 ();

  pipelined_segment_adder #(.WIDTH(WIDTH), .SEG(8)) dut (
    .clk (clk),
    .rst (rst),
    .ifc (ifc)
  );

  pipelined_segment_adder #(.WIDTH(WIDTH), .SEG(32)) dut1 (
    .clk (clk),
    .rst (rst),
    .ifc (ifc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  logic drv_valid, drv_cin, drv_sub, drv_ready, drv_rst;
  logic [31:0] drv_a, drv_b;
  res_t next_exp;
  res_t exp_q[$];
  bit   last_acc, last_ov;
  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    res_t        r;
    longint      sa, sb, sr;
    logic [32:0] full;
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      r.sum  = a - b;
      r.cout = (a >= b);
      sr     = sa - sb;
    end else begin
      full   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      r.sum  = full[31:0];
      r.cout = full[32];
      sr     = sa + sb + longint'(cin);
    end
    r.ovf = OVF_ON && (sr > 64'sd2147483647 || sr < -64'sd2147483648);
    return r;
  endfunction

  // One cycle: drive at negedge, sample 1ns later, score the handshakes.
  task automatic step();
    res_t e;
    @(negedge clk);
    rst           = drv_rst;
    ifc.in_valid  = drv_valid;
    ifc.in_a      = drv_a;
    ifc.in_b      = drv_b;
    ifc.in_cin    = drv_cin;
    ifc.in_sub    = drv_sub;
    ifc.out_ready = drv_ready;
    #1;
    chk("in_ready_rule", ifc.in_ready, !ifc.out_valid || ifc.out_ready);
    last_ov  = ifc.out_valid;
    last_acc = ifc.in_valid && ifc.in_ready;
    if (ifc.out_valid && ifc.out_ready) begin
      n_out++;
      chk("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sum", ifc.out_sum, e.sum);
        chk("cout", ifc.out_cout, e.cout);
        chk("ovf", ifc.out_ovf, e.ovf);
      end
    end
    if (last_acc) exp_q.push_back(next_exp);
  endtask

  task automatic drain();
    int k;
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    k = 0;
    while (exp_q.size() > 0 && k < 50) begin
      step();
      k++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, c, i, n0, stalls;
    bit  vin[24];
    bit  vout[24];

    vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vt[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vt[2] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vt[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vt[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vt[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
    vt[6] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
    vt[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

    rst = 1'b1;
    ifc.in_valid = 1'b0; ifc.in_a = '0; ifc.in_b = '0; ifc.in_cin = 1'b0;
    ifc.in_sub = 1'b0; ifc.out_ready = 1'b0;
    ifc1.in_valid = 1'b0; ifc1.in_a = '0; ifc1.in_b = '0; ifc1.in_cin = 1'b0;
    ifc1.in_sub = 1'b0; ifc1.out_ready = 1'b1;
    drv_rst = 1'b1; drv_valid = 1'b0; drv_ready = 1'b0;
    drv_a = '0; drv_b = '0; drv_cin = 1'b0; drv_sub = 1'b0;
    next_exp = '{32'd0, 1'b0, 1'b0};

    // Reset state, with out_ready low to show in_ready is still 1.
    step();
    step();
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_out_sum", ifc.out_sum, 0);
    chk("rst_out_cout", ifc.out_cout, 0);
    chk("rst_out_ovf", ifc.out_ovf, 0);
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst1_out_valid", ifc1.out_valid, 0);
    chk("rst1_out_sum", ifc1.out_sum, 0);
    drv_rst = 1'b0;
    drv_ready = 1'b1;
    step();

    // Table vectors, one isolated beat each, with latency check.
    foreach (vt[j]) begin
      drv_valid = 1'b1; drv_a = vt[j].a; drv_b = vt[j].b;
      drv_cin = vt[j].cin; drv_sub = vt[j].sub;
      next_exp = '{vt[j].sum, vt[j].cout, vt[j].ovf & OVF_ON};
      step();
      chk("tbl_accept", last_acc, 1);
      drv_valid = 1'b0;
      lat = 0;
      do begin
        step();
        lat++;
      end while (!last_ov && lat < 20);
      chk("tbl_latency", lat, STAGES);
      chk("tbl_consumed", exp_q.size(), 0);
    end

    // Backpressure: 8 beats, out_ready low on stream cycles 5..7.
    n0 = n_out; i = 0; c = 0; stalls = 0;
    while (i < 8 && c < 60) begin
      drv_valid = 1'b1; drv_a = 32'(i); drv_b = 32'(i); drv_cin = 1'b1; drv_sub = 1'b0;
      drv_ready = !(c >= 5 && c <= 7);
      next_exp = '{32'(2 * i + 1), 1'b0, 1'b0};
      step();
      if (!ifc.in_ready) stalls++;
      if (last_acc) i++;
      c++;
    end
    chk("bp_all_accepted", i, 8);
    chk("bp_stall_cycles", stalls, 3);
    drain();
    chk("bp_out_count", n_out - n0, 8);

    // Bubbles: alternating valid, out_valid must replay it STAGES cycles later.
    drv_ready = 1'b1;
    for (int t = 0; t < 24; t++) begin
      drv_valid = (t < 16) && (t % 2 == 0);
      drv_a = $urandom; drv_b = $urandom; drv_cin = 1'($urandom); drv_sub = 1'($urandom);
      next_exp = model(drv_a, drv_b, drv_cin, drv_sub);
      step();
      vin[t]  = last_acc;
      vout[t] = last_ov;
    end
    for (int t = STAGES; t < 24; t++) chk("bubble_pattern", vout[t], vin[t-STAGES]);
    drain();

    // Randomized traffic with random backpressure against the model.
    for (int t = 0; t < 400; t++) begin
      drv_valid = ($urandom % 4) != 0;
      drv_ready = ($urandom % 4) != 0;
      drv_a = ($urandom % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
      drv_b = ($urandom % 5 == 0) ? 32'h8000_0000 : $urandom;
      drv_cin = 1'($urandom);
      drv_sub = 1'($urandom);
      next_exp = model(drv_a, drv_b, drv_cin, drv_sub);
      step();
    end
    drain();

    // Reset mid-flight: three beats in the pipe must vanish.
    drv_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      drv_valid = 1'b1; drv_a = 32'(t + 100); drv_b = 32'(t); drv_cin = 1'b0; drv_sub = 1'b0;
      next_exp = model(drv_a, drv_b, drv_cin, drv_sub);
      step();
      chk("mid_accept", last_acc, 1);
    end
    drv_valid = 1'b0;
    drv_rst = 1'b1;
    step();
    exp_q.delete();
    drv_rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      step();
      chk("post_rst_idle", last_ov, 0);
    end

    // Single-stage configuration: one-cycle latency.
    for (int j = 0; j < 8; j += 3) begin
      @(negedge clk);
      ifc1.in_valid = 1'b1; ifc1.in_a = vt[j].a; ifc1.in_b = vt[j].b;
      ifc1.in_cin = vt[j].cin; ifc1.in_sub = vt[j].sub;
      #1;
      chk("s1_in_ready", ifc1.in_ready, 1);
      chk("s1_idle", ifc1.out_valid, 0);
      @(negedge clk);
      ifc1.in_valid = 1'b0;
      #1;
      chk("s1_valid", ifc1.out_valid, 1);
      chk("s1_sum", ifc1.out_sum, vt[j].sum);
      chk("s1_cout", ifc1.out_cout, vt[j].cout);
      chk("s1_ovf", ifc1.out_ovf, vt[j].ovf & OVF_ON);
      @(negedge clk);
      #1;
      chk("s1_valid_clear", ifc1.out_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipelined_segment_adder.md
# pipelined_segment_adder

Parametrised, pipelined successor to the flat segmented ripple adder. Splits a WIDTH-bit add/subtract into WIDTH/SEG segments, one segment per pipeline stage, with the inter-segment carry registered between stages. Offers a valid/ready stream interface so it can sit in datapaths that need a high clock rate and backpressure. One result per cycle at full throughput.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of SEG
- SEG, 8, segment width in bits; STAGES = WIDTH/SEG pipeline stages (≥1)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in (add mode only)
- in_sub  in  1  1 = A − B, 0 = A + B + cin
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry-out (sub mode: 1 = no borrow, i.e. A ≥ B unsigned)
- out_ovf  out  1  signed overflow flag (see Configuration)

## Operation
- Sub mode: effective B = ~in_b, effective carry-in = 1; in_cin ignored. Add mode: effective B = in_b, carry-in = in_cin.
- Stage k (0..STAGES−1) computes {c_k+1, s_k} = a_seg_k + b_seg_k + c_k, SEG+1 bits, no truncation before carry extraction.
- Stage k registers: valid bit, carry c_k+1, completed low sums s_0..s_k, remaining unconsumed upper segments of A and effective B, sub flag and operand MSBs needed for overflow.
- Final stage register drives out_sum, out_cout, out_ovf, out_valid directly (registered outputs, no combinational path from inputs).
- Global stall pipeline: adv = !out_valid || out_ready. in_ready = adv. When adv = 1 all stages shift one position; when 0 all stages hold.
- Beat accepted when in_valid && in_ready. Invalid beats (bubbles) propagate as valid=0 slots; bubbles are not collapsed.
- Data registers of invalid slots are don't-care; out_sum/out_cout/out_ovf are only defined when out_valid = 1.
- Arithmetic is modulo 2^WIDTH; out_cout is bit WIDTH of the full sum.
- STAGES = 1 (SEG = WIDTH): single registered adder, same handshake.

## Timing
- Reset: all stage valid bits 0; out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0; in_ready = 1 during and after reset.
- Reset mid-operation discards every in-flight beat; no result emerges for beats accepted before rst.
- Latency: beat accepted at edge N appears with out_valid = 1 after edge N+STAGES−1 (i.e. STAGES register stages), given no stall.
- Throughput: 1 beat/cycle while out_ready = 1.
- Stall: out_valid = 1 and out_ready = 0 → in_ready = 0, outputs and all stages hold stable until out_ready rises.
- Simultaneous out_ready rise and in_valid: beat accepted same cycle, output beat consumed same cycle.
- out_valid = 0 never stalls, regardless of out_ready.

## Configuration
- Macro PIPE_ADDER_OVF_EN.
- Defined: out_ovf = 1 when the signed result overflows: sign(A) == sign(effective B) and sign(out_sum) ≠ sign(A); MSB bits carried through the pipeline with the beat.
- Undefined: no MSB tracking registers; out_ovf tied to 0.

## Test plan
- WIDTH=32, SEG=8: reset, then A=0xFFFF_FFFF, B=0x0000_0001, cin=0, add → out_valid 4 cycles later, sum=0x0000_0000, cout=1; ovf=0.
- Sub: A=0x0000_0005, B=0x0000_0007 → sum=0xFFFF_FFFE, cout=0; A=7, B=5 → sum=2, cout=1.
- Overflow (macro defined): A=0x7FFF_FFFF, B=1, add → sum=0x8000_0000, ovf=1; macro undefined → ovf=0 same stimulus.
- Backpressure: stream 8 consecutive beats (A=i, B=i, cin=1) with out_ready low on cycles 5–7 → in_ready low exactly while out_valid && !out_ready, all 8 results 2i+1 delivered in order, none lost or duplicated.
- Bubbles: alternate in_valid 1/0 → out_valid pattern identical, delayed by 4 cycles.
- Reset mid-flight: accept 3 beats, assert rst one cycle → out_valid stays 0 afterwards, no stale result; STAGES=1 config (SEG=32) repeat first scenario with 1-cycle latency.
